lsu_mem_adapter: RTL

- Load/store unit between the core's memory stage and the data memory.
- Accepts one load/store request at a time through a valid/ready handshake.
- Checks alignment, range and funct3 legality, then generates the memory word address, byte mask and LSB-aligned write data.
- Extracts and sign/zero-extends load data, and returns one registered response per accepted request.

---
 rtl/lsu_mem_adapter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter: load/store unit bridging the core memory stage to a word-addressed data memory.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_write, req_funct3             store flag, RV32I width/sign code
//   req_addr, req_wdata               byte address, LSB-aligned store data
//   resp_valid                        one-cycle response strobe
//   resp_rdata, resp_error, resp_cause  extended load data, fault flag, fault cause
//   mem_address, mem_read, mem_write  word index and access strobes
//   mem_mask_byte, mem_write_data     byte-lane mask, LSB-aligned store value
//   mem_read_data                     combinational read word
module lsu_mem_adapter #(
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [1:0]  resp_cause,
    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mask_byte,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic [1:0]  cause_q, cause_d;

    logic        illegal, misaligned, out_of_range;
    logic [1:0]  cause;
    logic [31:0] word;
    logic [31:0] load_ext;
    logic        in_access;

    // Stores have no unsigned variants, so funct3[2] on a store is always illegal.
    assign illegal      = (req_funct3 == 3'd3) || (req_funct3[2] && req_funct3[1]) || (req_write && req_funct3[2]);
    assign misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign out_of_range = |req_addr[31:MEM_WORDS_LOG2+2];
    assign cause        = illegal ? 2'd3 : misaligned ? 2'd1 : out_of_range ? 2'd2 : 2'd0;

    assign word     = mem_read_data >> {addr_q[1:0], 3'b000};
    assign load_ext = funct3_q[1:0] == 2'b00 ? {{24{word[7] & ~funct3_q[2]}}, word[7:0]} :
                      funct3_q[1:0] == 2'b01 ? {{16{word[15] & ~funct3_q[2]}}, word[15:0]} : word;

    assign in_access      = state_q == ACCESS;
    assign req_ready      = state_q == IDLE;
    assign resp_valid     = state_q == RESP;
    // Response fields are gated so they read 0 in every cycle except the strobe.
    assign resp_rdata     = resp_valid ? rdata_q : 32'h0;
    assign resp_error     = resp_valid & error_q;
    assign resp_cause     = resp_valid ? cause_q : 2'd0;
    assign mem_address    = in_access ? addr_q[31:2] : 30'h0;
    assign mem_read       = in_access & ~write_q;
    assign mem_write      = in_access & write_q;
    assign mem_write_data = mem_write ? wdata_q : 32'h0;
    assign mem_mask_byte  = !mem_write ? 4'h0 :
                            funct3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                            funct3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        cause_d  = cause_q;
        if (state_q == IDLE) begin
            if (req_valid) begin
                write_d  = req_write;
                funct3_d = req_funct3;
                addr_d   = req_addr;
                wdata_d  = req_wdata;
                rdata_d  = 32'h0;
                error_d  = cause != 2'd0;
                cause_d  = cause;
                state_d  = cause != 2'd0 ? RESP : ACCESS;
            end
        end else if (state_q == ACCESS) begin
            rdata_d = write_q ? 32'h0 : load_ext;
            state_d = RESP;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
            cause_q  <= cause_d;
        end
    end
endmodule
